// File: rtl/uart_tx_arbiter.sv
// Shares one UART_Tx byte transmitter between two 32-bit word requesters, sending each word LSB byte first.
// Define UART_TX_ARB_FIXED_PRIO_EN to give requester 0 fixed priority (default build: round-robin).
module uart_tx_arbiter #(
  parameter logic [15:0] CLKS_PER_BIT = 16'd10417,
  parameter logic [31:0] GAP_CLKS     = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  output logic [1:0]  req_ack,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  input  logic        tx_active,
  input  logic        tx_done,
  output logic        busy,
  output logic        owner
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] BYTES_PER_WORD = CNT_W'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_GAP,
    S_ACK
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]         gap_cnt_q, gap_cnt_d;
  logic                rr_last_q, rr_last_d;
  logic                owner_q, owner_d;
  logic [1:0]          req_ack_q, req_ack_d;
  logic                tx_dv_q, tx_dv_d;
  logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
  logic                busy_q, busy_d;
  logic                winner_c;
  logic                unused_cfg;

  // Bit timing belongs to UART_Tx; the arbiter only paces on tx_done.
  assign unused_cfg = ^{CLKS_PER_BIT, rr_last_q};

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  assign winner_c = ~req_valid[0];
`else
  assign winner_c = (&req_valid) ? ~rr_last_q : req_valid[1];
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rr_last_d  = rr_last_q;
    owner_d    = owner_q;
    req_ack_d  = 2'b00;
    tx_dv_d    = 1'b0;
    tx_byte_d  = tx_byte_q;
    busy_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          word_d     = winner_c ? req_data1 : req_data0;
          owner_d    = winner_c;
          rr_last_d  = winner_c;
          byte_cnt_d = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!tx_active) state_d = S_START;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
          word_d     = word_q >> BYTE_W;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (GAP_CLKS == 32'd0) begin
            if (byte_cnt_d == BYTES_PER_WORD) state_d = S_ACK;
            else                              state_d = S_START;
          end else begin
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_CLKS - 32'd1) begin
          if (byte_cnt_q == BYTES_PER_WORD) state_d = S_ACK;
          else                              state_d = S_START;
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    if (state_d == S_ACK) req_ack_d = owner_d ? 2'b10 : 2'b01;
    if (state_d == S_START) begin
      tx_dv_d   = 1'b1;
      tx_byte_d = word_d[BYTE_W-1:0];
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      rr_last_q  <= 1'b1;
      owner_q    <= 1'b0;
      req_ack_q  <= 2'b00;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      rr_last_q  <= rr_last_d;
      owner_q    <= owner_d;
      req_ack_q  <= req_ack_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      busy_q     <= busy_d;
    end
  end

  assign req_ack = req_ack_q;
  assign tx_dv   = tx_dv_q;
  assign tx_byte = tx_byte_q;
  assign busy    = busy_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, corner-case sequences and a randomized run against a word-level model.
module tb_uart_tx_arbiter;

  localparam int unsigned CPB   = 4;
  localparam int unsigned GAP   = 100;
  localparam int unsigned FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [31:0] req_data0, req_data1;
  logic [1:0]  req_ack;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active, tx_done;
  logic        busy, owner;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.CLKS_PER_BIT(16'(CPB)), .GAP_CLKS(32'(GAP))) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data0(req_data0),
    .req_data1(req_data1), .req_ack(req_ack), .tx_dv(tx_dv), .tx_byte(tx_byte),
    .tx_active(tx_active), .tx_done(tx_done), .busy(busy), .owner(owner)
  );

  typedef struct {
    logic [1:0]  v;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        exp_rr;
    logic        exp_fx;
  } vec_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          uart_left = 0;
  bit          uart_en = 1'b1;
  int          last_done_cyc = 0;
  bit          done_seen = 1'b0;
  int          n_done = 0;
  bit          last_busy = 1'b0;
  bit          rose = 1'b0;
  logic [7:0]  got[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Arbitration rule at word granularity
  function automatic logic arb(input logic [1:0] v, input logic last);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    if (v[0]) return 1'b0;
    return 1'b1;
`else
    if (v == 2'b11) return ~last;
    if (v == 2'b10) return 1'b1;
    return 1'b0;
`endif
  endfunction

  // One clock: sample at negedge, collect bytes, and model UART_Tx framing.
  task automatic tick();
    @(negedge clk);
    cyc++;
    rose      = busy && !last_busy;
    last_busy = busy;
    tx_done   = 1'b0;
    if (tx_dv) begin
      if (got.size() > 0 && done_seen)
        cmp("byte_spacing", 32'(cyc - last_done_cyc), 32'(GAP + 1));
      got.push_back(tx_byte);
      if (uart_en) begin
        uart_left = FRAME;
        tx_active = 1'b1;
      end
    end else if (uart_en && uart_left > 0) begin
      uart_left--;
      if (uart_left == 0) begin
        tx_active = 1'b0;
        tx_done   = 1'b1;
        last_done_cyc = cyc;
        done_seen = 1'b1;
        n_done++;
        if (got.size() > 0) cmp("tx_byte_hold", 32'(tx_byte), 32'(got[got.size()-1]));
      end
    end
  endtask

  task automatic check_word(input logic [31:0] w, input string name);
    cmp({name, "_nbytes"}, 32'(got.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < got.size()) cmp({name, "_byte"}, 32'(got[k]), 32'(w[8*k +: 8]));
    got.delete();
    done_seen = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    uart_left = 0;
    tx_active = 1'b0;
    tick();
    tick();
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_owner", 32'(owner), 32'd0);
    cmp("rst_tx_dv", 32'(tx_dv), 32'd0);
    cmp("rst_tx_byte", 32'(tx_byte), 32'd0);
    cmp("rst_req_ack", 32'(req_ack), 32'd0);
    reset = 1'b0;
    got.delete();
    done_seen = 1'b0;
  endtask

  // Serve one word from grant to ack; exp_owner comes from the bench's expectation.
  task automatic run_word(input logic exp_owner, input string name);
    logic [31:0] w = 32'h0;
    bit granted = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      tick();
      if (rose) begin
        granted = 1'b1;
        cmp({name, "_owner"}, 32'(owner), 32'(exp_owner));
        w = exp_owner ? req_data1 : req_data0;
      end
      if (req_ack != 2'b00) begin
        cmp({name, "_ack"}, 32'(req_ack), exp_owner ? 32'd2 : 32'd1);
        cmp({name, "_granted"}, 32'(granted), 32'd1);
        check_word(w, name);
        tick();
        cmp({name, "_busy_after"}, 32'(busy), 32'd0);
        cmp({name, "_ack_once"}, 32'(req_ack), 32'd0);
        return;
      end
    end
    fail_timeout(name);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[9];
    logic [31:0] w;
    logic [31:0] q0[$], q1[$];
    logic        eo, rr;
    logic [1:0]  idle_v;
    int          acks, start, dv_cnt;
    bit          expect_idle, done_ok;

    tbl[0] = '{2'b11, 32'hA1A2A3A4, 32'hB1B2B3B4, 1'b0, 1'b0};
    tbl[1] = '{2'b11, 32'hA1A2A3A4, 32'hB1B2B3B4, 1'b1, 1'b0};
    tbl[2] = '{2'b11, 32'hA1A2A3A4, 32'hB1B2B3B4, 1'b0, 1'b0};
    tbl[3] = '{2'b01, 32'h44332211, 32'h00000000, 1'b0, 1'b0};
    tbl[4] = '{2'b10, 32'h00000000, 32'hC0FFEE01, 1'b1, 1'b1};
    tbl[5] = '{2'b11, 32'hD0D1D2D3, 32'hE0E1E2E3, 1'b0, 1'b0};
    tbl[6] = '{2'b11, 32'hD0D1D2D3, 32'hE0E1E2E3, 1'b1, 1'b0};
    tbl[7] = '{2'b10, 32'h00000000, 32'h5A5AA5A5, 1'b1, 1'b1};
    tbl[8] = '{2'b11, 32'h01020304, 32'h0F0E0D0C, 1'b0, 1'b0};

    reset = 1'b1; req_valid = 2'b00; req_data0 = '0; req_data1 = '0;
    tx_active = 1'b0; tx_done = 1'b0;
    do_reset();

    // Table of single-word transactions; grant history carries across rows.
    for (int i = 0; i < 9; i++) begin
      req_valid = tbl[i].v;
      req_data0 = tbl[i].d0;
      req_data1 = tbl[i].d1;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      eo = tbl[i].exp_fx;
`else
      eo = tbl[i].exp_rr;
`endif
      run_word(eo, "table");
    end
    req_valid = 2'b00;
    repeat (3) tick();
    cmp("idle_after_table", 32'(busy), 32'd0);

    // Grant while a byte is still in flight; valid dropped and data changed after grant.
    uart_en = 1'b0; tx_active = 1'b1;
    req_valid = 2'b10; req_data1 = 32'h87654321;
    done_ok = 1'b0;
    for (int t = 0; t < 10 && !done_ok; t++) begin
      tick();
      if (rose) done_ok = 1'b1;
    end
    if (!done_ok) fail_timeout("active_grant");
    cmp("active_owner", 32'(owner), 32'd1);
    w = req_data1;
    req_valid = 2'b00; req_data1 = 32'hFFFFFFFF;
    dv_cnt = 0;
    repeat (20) begin
      tick();
      if (tx_dv) dv_cnt++;
    end
    cmp("no_dv_while_active", 32'(dv_cnt), 32'd0);
    got.delete();
    tx_active = 1'b0; uart_en = 1'b1;
    start = cyc;
    tick();
    tick();
    cmp("dv_after_active_falls", 32'(got.size()), 32'd1);
    done_ok = 1'b0;
    for (int t = 0; t < 3000 && !done_ok; t++) begin
      tick();
      if (req_ack != 2'b00) begin
        done_ok = 1'b1;
        cmp("active_ack", 32'(req_ack), 32'd2);
        check_word(w, "active_word");
      end
    end
    if (!done_ok) fail_timeout("active_ack");
    repeat (2) tick();

    // Stray tx_done while idle.
    uart_en = 1'b0;
    tick();
    tx_done = 1'b1;
    dv_cnt = 0;
    repeat (4) begin
      tick();
      if (tx_dv || busy) dv_cnt++;
    end
    cmp("stray_done_idle", 32'(dv_cnt), 32'd0);
    uart_en = 1'b1;

    // Reset after the second byte's tx_done abandons the word.
    req_valid = 2'b01; req_data0 = 32'h55667788;
    start = n_done;
    done_ok = 1'b0;
    for (int t = 0; t < 2000 && !done_ok; t++) begin
      tick();
      if (n_done - start >= 2) done_ok = 1'b1;
    end
    if (!done_ok) fail_timeout("mid_reset_wait");
    reset = 1'b1;
    tick();
    cmp("mid_reset_busy", 32'(busy), 32'd0);
    cmp("mid_reset_dv", 32'(tx_dv), 32'd0);
    cmp("mid_reset_ack", 32'(req_ack), 32'd0);
    reset = 1'b0; uart_left = 0; tx_active = 1'b0;
    got.delete(); done_seen = 1'b0;
    req_valid = 2'b11; req_data0 = 32'h0D0C0B0A; req_data1 = 32'h1F1E1D1C;
    run_word(1'b0, "after_reset");
    req_valid = 2'b00;

    // Randomized traffic checked against a word-level arbitration model.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      q0.push_back($urandom);
      q1.push_back($urandom);
    end
    rr = 1'b1; idle_v = 2'b00; acks = 0; expect_idle = 1'b0; eo = 1'b0; w = '0;
    for (int t = 0; t < 20000 && acks < 16; t++) begin
      tick();
      if (expect_idle) begin
        cmp("rand_idle_after_ack", 32'(busy), 32'd0);
        expect_idle = 1'b0;
      end
      if (rose) begin
        eo = arb(idle_v, rr);
        rr = eo;
        cmp("rand_owner", 32'(owner), 32'(eo));
        w = eo ? q1[0] : q0[0];
      end
      if (req_ack != 2'b00) begin
        cmp("rand_ack", 32'(req_ack), eo ? 32'd2 : 32'd1);
        check_word(w, "rand_word");
        if (eo) void'(q1.pop_front());
        else    void'(q0.pop_front());
        req_valid[eo] = 1'b0;
        acks++;
        expect_idle = 1'b1;
      end
      if (!req_valid[0] && q0.size() > 0 && $urandom_range(0, 3) == 0) begin
        req_valid[0] = 1'b1;
        req_data0 = q0[0];
      end
      if (!req_valid[1] && q1.size() > 0 && $urandom_range(0, 3) == 0) begin
        req_valid[1] = 1'b1;
        req_data1 = q1[0];
      end
      if (!busy) idle_v = req_valid;
    end
    if (acks < 16) fail_timeout("rand_words");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
